// File: rtl/mem_ops_pkg.sv
// Shared store/load unit encodings: store control codes and store FSM states.
package mem_ops_pkg;

  typedef enum logic [2:0] {
    ST_NOP = 3'b000,
    SB     = 3'b001,
    SH     = 3'b010,
    SW     = 3'b011
  } st_ctrl_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } st_state_t;

  function automatic logic is_rmw(input st_ctrl_t c);
    return (c == SB) || (c == SH);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Lane merge for sub-word stores: splices new byte/halfword into the old memory word.
// Purely combinational, zero latency, no flow control.
module store_merge
  import mem_ops_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] new_data,
  input  logic [1:0]  lane,
  input  st_ctrl_t    ctrl,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (ctrl)
      SB: begin
        case (lane)
          2'd0: merged[7:0]   = new_data[7:0];
          2'd1: merged[15:8]  = new_data[7:0];
          2'd2: merged[23:16] = new_data[7:0];
          2'd3: merged[31:24] = new_data[7:0];
          default: merged = old_word;
        endcase
      end
      // Halfword lane is picked by lane[1] only; lane[0] is a don't-care here.
      SH: begin
        if (lane[1]) merged[31:16] = new_data;
        else         merged[15:0]  = new_data;
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// RV32 store unit on a word-wide memory: SW writes in 1 cycle, SB/SH do read-modify-write in 2.
// Stalls PC during the RMW read and other exec during the RMW write; STORE_MISALIGN_TRAP_EN adds a misalign trap.
module store_unit
  import mem_ops_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       rs1_val,
  input  logic [31:0]       rs2_val,
  input  logic [31:0]       imm,
  input  logic [2:0]        store_control,
  input  logic [31:0]       mem_rdata,
  output logic              stall_pc,
  output logic              stall_other_exec,
  output logic              mem_rw_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic              store_misalign
`endif
);

  logic [31:0]       eff_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        lane;
  st_ctrl_t          ctrl;
  st_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [15:0]       data_q;
  st_ctrl_t          ctrl_q;
  logic              start_rmw;
  logic              misalign;
  logic [31:0]       merged;
  logic              unused_bits;

  assign eff_addr    = rs1_val + imm;
  assign word_addr   = eff_addr[ADDR_W+1:2];
  assign lane        = eff_addr[1:0];
  assign ctrl        = st_ctrl_t'(store_control);
  assign unused_bits = ^{eff_addr[31:ADDR_W+2], rs2_val[31:16]};

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign       = ((ctrl == SH) && lane[0]) || ((ctrl == SW) && (lane != 2'b00));
  assign store_misalign = (state_q == ST_IDLE) && misalign;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    mem_rw_mode      = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    stall_pc         = 1'b0;
    stall_other_exec = 1'b0;
    start_rmw        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!misalign) begin
          if (ctrl == SW) begin
            mem_rw_mode = 1'b1;
            mem_addr    = word_addr;
            mem_wdata   = rs2_val;
          end else if (is_rmw(ctrl)) begin
            mem_addr  = word_addr;
            stall_pc  = 1'b1;
            start_rmw = 1'b1;
            state_d   = ST_MERGE;
          end
        end
      end
      // Inputs are ignored here; the RMW write uses only captured fields and mem_rdata.
      ST_MERGE: begin
        mem_rw_mode      = 1'b1;
        mem_addr         = addr_q;
        mem_wdata        = merged;
        stall_other_exec = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= ST_NOP;
    end else begin
      state_q <= state_d;
      if (start_rmw) begin
        addr_q <= word_addr;
        lane_q <= lane;
        data_q <= rs2_val[15:0];
        ctrl_q <= ctrl;
      end
    end
  end

  store_merge u_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .lane     (lane_q),
    .ctrl     (ctrl_q),
    .merged   (merged)
  );

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: word memory model, write scoreboard, directed and random stores.
module tb_store_unit;
  import mem_ops_pkg::*;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] imm = '0;
  logic [2:0]  store_control = ST_NOP;
  logic [31:0] mem_rdata;
  logic        stall_pc, stall_other_exec, mem_rw_mode;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        store_misalign;
`endif

  logic        mem_clr = 1'b1;
  logic [31:0] tb_mem [0:1023];
  logic [31:0] shadow [0:1023];
  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;

  store_unit #(.ADDR_W(10)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .imm              (imm),
    .store_control    (store_control),
    .mem_rdata        (mem_rdata),
    .stall_pc         (stall_pc),
    .stall_other_exec (stall_other_exec),
    .mem_rw_mode      (mem_rw_mode),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata)
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    .store_misalign   (store_misalign)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Single-port memory: read data appears the cycle after the address.
  always @(posedge i_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= '0;
    end else if (mem_rw_mode) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (mem_rw_mode) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [2:0] c,
                                            input logic [1:0] ln, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (c == SB) sh = 8 * int'(ln);
    else         sh = ln[1] ? 16 : 0;
    m = ((c == SB) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~m) | ((d << sh) & m);
  endfunction

  task automatic do_store(input logic [2:0] c, input logic [31:0] rs1, input logic [31:0] off,
                          input logic [31:0] rs2, input logic [9:0] exp_wa, input logic [31:0] exp_wd);
    wr_t e;
    @(posedge i_clk); #1;
    store_control = c; rs1_val = rs1; imm = off; rs2_val = rs2;
    e.a = exp_wa; e.d = exp_wd;
    exp_q.push_back(e);
    @(negedge i_clk);
    if (c == SW) begin
      chk("sw_rw", 32'(mem_rw_mode), 32'd1);
      chk("sw_stall_pc", 32'(stall_pc), 32'd0);
      chk("sw_stall_oe", 32'(stall_other_exec), 32'd0);
    end else begin
      chk("rmw_rd_rw", 32'(mem_rw_mode), 32'd0);
      chk("rmw_rd_addr", 32'(mem_addr), 32'(exp_wa));
      chk("rmw_rd_stall_pc", 32'(stall_pc), 32'd1);
      chk("rmw_rd_stall_oe", 32'(stall_other_exec), 32'd0);
      // Drive a conflicting SW during the merge cycle; it must be ignored.
      @(posedge i_clk); #1;
      store_control = SW; rs2_val = ~rs2; rs1_val = $urandom;
      @(negedge i_clk);
      chk("rmw_wr_rw", 32'(mem_rw_mode), 32'd1);
      chk("rmw_wr_stall_pc", 32'(stall_pc), 32'd0);
      chk("rmw_wr_stall_oe", 32'(stall_other_exec), 32'd1);
    end
    shadow[exp_wa] = exp_wd;
  endtask

  task automatic idle_cycle();
    @(posedge i_clk); #1;
    store_control = ST_NOP;
    @(negedge i_clk);
    chk("idle_rw", 32'(mem_rw_mode), 32'd0);
    chk("idle_stall_pc", 32'(stall_pc), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2, off, eff, ed;
    logic [2:0]  c;
    for (int i = 0; i < 1024; i++) shadow[i] = '0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_rw", 32'(mem_rw_mode), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_stall_pc", 32'(stall_pc), 32'd0);
    chk("rst_stall_oe", 32'(stall_other_exec), 32'd0);
    #1; i_rst_n = 1'b1;
    @(posedge i_clk); #1; mem_clr = 1'b0;
    idle_cycle();

    // SW: 0x100+4 -> word 0x41
    do_store(SW, 32'h100, 32'h4, 32'hDEADBEEF, 10'h041, 32'hDEADBEEF);
    // SB: word 0x80 = 0x11223344, byte lane 2 <- 0xAB
    do_store(SW, 32'h200, 32'h0, 32'h11223344, 10'h080, 32'h11223344);
    do_store(SB, 32'h200, 32'h2, 32'h000000AB, 10'h080, 32'h11AB3344);
    // SH: upper half at 0x202
    do_store(SW, 32'h200, 32'h0, 32'h11223344, 10'h080, 32'h11223344);
    do_store(SH, 32'h200, 32'h2, 32'h0000CAFE, 10'h080, 32'hCAFE3344);

    // Back-to-back SB across all four lanes of word 0xC0
    do_store(SW, 32'h300, 32'h0, 32'h0, 10'h0C0, 32'h0);
    do_store(SB, 32'h300, 32'h0, 32'h000000AA, 10'h0C0, 32'h000000AA);
    do_store(SB, 32'h300, 32'h1, 32'h000000BB, 10'h0C0, 32'h0000BBAA);
    do_store(SB, 32'h300, 32'h2, 32'h000000CC, 10'h0C0, 32'h00CCBBAA);
    do_store(SB, 32'h300, 32'h3, 32'h000000DD, 10'h0C0, 32'hDDCCBBAA);
    idle_cycle();
    @(negedge i_clk);
    chk("b2b_final_word", tb_mem[10'h0C0], 32'hDDCCBBAA);

    // Reset during ST_MERGE abandons the write
    do_store(SW, 32'h400, 32'h0, 32'h55667788, 10'h100, 32'h55667788);
    @(posedge i_clk); #1;
    store_control = SB; rs1_val = 32'h400; imm = 32'h1; rs2_val = 32'h99;
    @(negedge i_clk);
    chk("rstm_rd_stall_pc", 32'(stall_pc), 32'd1);
    @(posedge i_clk); #1;
    store_control = ST_NOP;
    #2; i_rst_n = 1'b0;
    #1;
    chk("rstm_rw", 32'(mem_rw_mode), 32'd0);
    chk("rstm_stall_oe", 32'(stall_other_exec), 32'd0);
    repeat (2) @(negedge i_clk);
    chk("rstm_mem_kept", tb_mem[10'h100], 32'h55667788);
    #1; i_rst_n = 1'b1;
    idle_cycle();
    do_store(SB, 32'h400, 32'h2, 32'h77, 10'h100, 32'h55777788);

    // SH at 0x201
    do_store(SW, 32'h200, 32'h0, 32'h11223344, 10'h080, 32'h11223344);
`ifdef STORE_MISALIGN_TRAP_EN
    @(posedge i_clk); #1;
    store_control = SH; rs1_val = 32'h200; imm = 32'h1; rs2_val = 32'h1234;
    @(negedge i_clk);
    chk("mis_flag", 32'(store_misalign), 32'd1);
    chk("mis_rw", 32'(mem_rw_mode), 32'd0);
    chk("mis_stall_pc", 32'(stall_pc), 32'd0);
    idle_cycle();
    chk("mis_flag_clear", 32'(store_misalign), 32'd0);
    @(negedge i_clk);
    chk("mis_mem_kept", tb_mem[10'h080], 32'h11223344);
`else
    do_store(SH, 32'h200, 32'h1, 32'h1234, 10'h080, 32'h11221234);
`endif

    // Random stores, including wrapping addresses and odd SW lanes
    for (int n = 0; n < 12; n++) begin
      c   = 3'(1 + $urandom_range(0, 2));
      r1  = $urandom;
      off = $urandom_range(0, 15);
      r2  = $urandom;
`ifdef STORE_MISALIGN_TRAP_EN
      if (c == SW) begin r1 = r1 & ~32'h3; off = off & ~32'h3; end
      if (c == SH) begin r1 = r1 & ~32'h1; off = off & ~32'h1; end
`endif
      eff = r1 + off;
      ed  = (c == SW) ? r2 : ref_merge(shadow[eff[11:2]], c, eff[1:0], r2);
      do_store(c, r1, off, r2, eff[11:2], ed);
    end
    idle_cycle();
    idle_cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
